// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic [ADDR_W-1:0] wr;
        logic [REG_W-1:0]  d;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding pending writebacks for one producer.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = slots[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full queue refuses a push even if its head pops on the same edge.
    assign do_push = push && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin scheduler of ALU/load writebacks onto the single register-file write port,
// with a per-register pending-write scoreboard. Define REGFILE_WB_FWD_EN for write-port forwarding outputs.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_wr,
    input  logic [REG_W-1:0]  alu_d,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wr,
    input  logic [REG_W-1:0]  mem_d,
    input  logic              hold,
`ifdef REGFILE_WB_FWD_EN
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [REG_W-1:0]  fwd_d,
`endif
    output logic              We,
    output logic [ADDR_W-1:0] Wr,
    output logic [REG_W-1:0]  D,
    output logic [NREG-1:0]   busy
);

    localparam int               CNT_W  = $clog2(2 * DEPTH + 1);
    localparam logic [CNT_W:0]   SB_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   SB_MAX = (CNT_W + 1)'(2 * DEPTH);

    wb_req_t          alu_in;
    wb_req_t          mem_in;
    wb_req_t          alu_head;
    wb_req_t          mem_head;
    logic             alu_full;
    logic             alu_empty;
    logic             mem_full;
    logic             mem_empty;
    logic             alu_acc;
    logic             mem_acc;
    logic             alu_push;
    logic             mem_push;
    logic             grant_alu;
    logic             grant_mem;
    wb_src_t          last_grant;
    logic [CNT_W-1:0] sb_cnt  [NREG];
    logic [CNT_W:0]   sb_next [NREG];

    assign alu_in = '{wr: alu_wr, d: alu_d};
    assign mem_in = '{wr: mem_wr, d: mem_d};

    assign alu_ready = !Rst && !alu_full;
    assign mem_ready = !Rst && !mem_full;
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;
    // Writes to r0 are swallowed at the door: no queue slot, no scoreboard entry.
    assign alu_push  = alu_acc && (alu_wr != '0);
    assign mem_push  = mem_acc && (mem_wr != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_alu_fifo (
        .clk       (Clk),
        .rst       (Rst),
        .push      (alu_push),
        .push_data (alu_in),
        .pop       (grant_alu),
        .head      (alu_head),
        .empty     (alu_empty),
        .full      (alu_full)
    );

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_mem_fifo (
        .clk       (Clk),
        .rst       (Rst),
        .push      (mem_push),
        .push_data (mem_in),
        .pop       (grant_mem),
        .head      (mem_head),
        .empty     (mem_empty),
        .full      (mem_full)
    );

    // Round-robin: with both heads present, the source not granted last time wins.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!Rst && !hold) begin
            if (!alu_empty && (mem_empty || last_grant == SRC_MEM)) begin
                grant_alu = 1'b1;
            end else if (!mem_empty) begin
                grant_mem = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_grant <= SRC_MEM;
        end else if (grant_alu) begin
            last_grant <= SRC_ALU;
        end else if (grant_mem) begin
            last_grant <= SRC_MEM;
        end
    end

    always_comb begin
        We = 1'b0;
        Wr = '0;
        D  = '0;
        if (grant_alu) begin
            We = 1'b1;
            Wr = alu_head.wr;
            D  = alu_head.d;
        end else if (grant_mem) begin
            We = 1'b1;
            Wr = mem_head.wr;
            D  = mem_head.d;
        end
    end

    // One extra bit on the next value lets the overflow/underflow check see wraparound.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb_next[i] = {1'b0, sb_cnt[i]};
            if (alu_push && alu_wr == ADDR_W'(i)) begin
                sb_next[i] = sb_next[i] + SB_ONE;
            end
            if (mem_push && mem_wr == ADDR_W'(i)) begin
                sb_next[i] = sb_next[i] + SB_ONE;
            end
            if (We && Wr == ADDR_W'(i)) begin
                sb_next[i] = sb_next[i] - SB_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) begin
                sb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                sb_cnt[i] <= sb_next[i][CNT_W-1:0];
                assert (sb_next[i] <= SB_MAX);
            end
        end
    end

    always_comb begin
        busy = '0;
        if (!Rst) begin
            for (int i = 0; i < NREG; i++) begin
                busy[i] = (sb_cnt[i] != '0);
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    assign fwd_a = We && (Wr == Ra) && (Wr != '0);
    assign fwd_b = We && (Wr == Rb) && (Wr != '0);
    assign fwd_d = D;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] d;
    } tb_req_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_wr;
    logic [31:0] alu_d;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wr;
    logic [31:0] mem_d;
    logic        hold;
    logic        We;
    logic [4:0]  Wr;
    logic [31:0] D;
    logic [31:0] busy;
`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] fwd_d;
`endif

    int checks   = 0;
    int failures = 0;

    tb_req_t alu_send[$];
    tb_req_t mem_send[$];
    tb_req_t alu_q[$];
    tb_req_t mem_q[$];
    int      pending [32];
    bit      last_alu;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wr    (alu_wr),
        .alu_d     (alu_d),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wr    (mem_wr),
        .mem_d     (mem_d),
        .hold      (hold),
`ifdef REGFILE_WB_FWD_EN
        .Ra        (Ra),
        .Rb        (Rb),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .fwd_d     (fwd_d),
`endif
        .We        (We),
        .Wr        (Wr),
        .D         (D),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic queueReq(input bit to_mem, input int wr, input logic [31:0] d);
        tb_req_t r;
        r.wr = 5'(wr);
        r.d  = d;
        if (to_mem) mem_send.push_back(r);
        else        alu_send.push_back(r);
    endtask

    // One clock cycle: drive, check model expectations at negedge, advance model at posedge.
    task automatic applyStimulus(input bit h, input bit r);
        tb_req_t     a;
        tb_req_t     m;
        int          gnt;
        bit          exp_ar;
        bit          exp_mr;
        bit          a_acc;
        bit          m_acc;
        logic        exp_we;
        logic [4:0]  exp_wr;
        logic [31:0] exp_d;
        logic [31:0] exp_busy;

        gnt = 0;
        if (!r && !h) begin
            if (alu_q.size() != 0 && mem_q.size() != 0) gnt = last_alu ? 2 : 1;
            else if (alu_q.size() != 0)                gnt = 1;
            else if (mem_q.size() != 0)                gnt = 2;
        end
        exp_we = (gnt != 0);
        exp_wr = 5'd0;
        exp_d  = 32'd0;
        if (gnt == 1) begin
            exp_wr = alu_q[0].wr;
            exp_d  = alu_q[0].d;
        end else if (gnt == 2) begin
            exp_wr = mem_q[0].wr;
            exp_d  = mem_q[0].d;
        end
        exp_ar = !r && (alu_q.size() < DEPTH);
        exp_mr = !r && (mem_q.size() < DEPTH);
        for (int i = 0; i < 32; i++) exp_busy[i] = !r && (pending[i] != 0);

        a.wr = 5'd0; a.d = 32'd0;
        m.wr = 5'd0; m.d = 32'd0;
        if (alu_send.size() != 0) a = alu_send[0];
        if (mem_send.size() != 0) m = mem_send[0];
        Rst       = r;
        hold      = h;
        alu_valid = (alu_send.size() != 0);
        alu_wr    = a.wr;
        alu_d     = a.d;
        mem_valid = (mem_send.size() != 0);
        mem_wr    = m.wr;
        mem_d     = m.d;
`ifdef REGFILE_WB_FWD_EN
        Ra = ($urandom_range(0, 1) == 1) ? exp_wr : 5'($urandom_range(0, 31));
        Rb = ($urandom_range(0, 1) == 1) ? exp_wr : 5'($urandom_range(0, 31));
`endif
        a_acc = alu_valid && exp_ar;
        m_acc = mem_valid && exp_mr;

        @(negedge Clk);
        checkOutput("we",        32'(We),        32'(exp_we));
        checkOutput("wr",        32'(Wr),        32'(exp_wr));
        checkOutput("d",         D,              exp_d);
        checkOutput("busy",      busy,           exp_busy);
        checkOutput("alu_ready", 32'(alu_ready), 32'(exp_ar));
        checkOutput("mem_ready", 32'(mem_ready), 32'(exp_mr));
`ifdef REGFILE_WB_FWD_EN
        checkOutput("fwd_a", 32'(fwd_a), 32'(exp_we && exp_wr == Ra && exp_wr != 5'd0));
        checkOutput("fwd_b", 32'(fwd_b), 32'(exp_we && exp_wr == Rb && exp_wr != 5'd0));
        checkOutput("fwd_d", fwd_d, exp_d);
`endif

        @(posedge Clk);
        if (r) begin
            alu_q.delete();
            mem_q.delete();
            for (int i = 0; i < 32; i++) pending[i] = 0;
            last_alu = 1'b0;
        end else begin
            if (gnt == 1) begin
                pending[alu_q[0].wr]--;
                void'(alu_q.pop_front());
                last_alu = 1'b1;
            end else if (gnt == 2) begin
                pending[mem_q[0].wr]--;
                void'(mem_q.pop_front());
                last_alu = 1'b0;
            end
            if (a_acc) begin
                void'(alu_send.pop_front());
                if (a.wr != 5'd0) begin
                    alu_q.push_back(a);
                    pending[a.wr]++;
                end
            end
            if (m_acc) begin
                void'(mem_send.pop_front());
                if (m.wr != 5'd0) begin
                    mem_q.push_back(m);
                    pending[m.wr]++;
                end
            end
        end
        #1;
    endtask

    function automatic int randReg();
        return ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
    endfunction

    initial begin
        Rst = 1'b1; hold = 1'b0;
        alu_valid = 1'b0; alu_wr = '0; alu_d = '0;
        mem_valid = 1'b0; mem_wr = '0; mem_d = '0;
`ifdef REGFILE_WB_FWD_EN
        Ra = '0; Rb = '0;
`endif
        for (int i = 0; i < 32; i++) pending[i] = 0;
        last_alu = 1'b0;
        @(posedge Clk);
        #1;

        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);

        $display("[TB] single ALU write r5");
        queueReq(1'b0, 5, 32'h0000_1234);
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("[TB] contention r1..r6");
        for (int k = 0; k < 3; k++) begin
            queueReq(1'b0, 1 + 2 * k, 32'hA000_0000 + 32'(k));
            queueReq(1'b1, 2 + 2 * k, 32'hB000_0000 + 32'(k));
        end
        repeat (9) applyStimulus(1'b0, 1'b0);

        $display("[TB] register 0");
        queueReq(1'b0, 0, 32'hFFFF_FFFF);
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("[TB] same-register overlap r7");
        queueReq(1'b0, 7, 32'h7777_0001);
        queueReq(1'b1, 7, 32'h7777_0002);
        repeat (4) applyStimulus(1'b0, 1'b0);

        $display("[TB] hold with full queues");
        for (int k = 0; k < 2; k++) begin
            queueReq(1'b0, 11 + k, 32'hC000_0000 + 32'(k));
            queueReq(1'b1, 13 + k, 32'hD000_0000 + 32'(k));
        end
        repeat (4) applyStimulus(1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0);

        $display("[TB] reset mid-drain");
        for (int k = 0; k < 2; k++) begin
            queueReq(1'b0, 20 + k, 32'hE000_0000 + 32'(k));
            queueReq(1'b1, 22 + k, 32'hF000_0000 + 32'(k));
        end
        repeat (2) applyStimulus(1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0);

`ifdef REGFILE_WB_FWD_EN
        $display("[TB] forwarding r9");
        queueReq(1'b0, 9, 32'h0000_ABCD);
        repeat (3) applyStimulus(1'b0, 1'b0);
`endif

        $display("[TB] randomized traffic");
        repeat (800) begin
            if (alu_send.size() == 0 && $urandom_range(0, 2) != 0)
                queueReq(1'b0, randReg(), $urandom);
            if (mem_send.size() == 0 && $urandom_range(0, 2) != 0)
                queueReq(1'b1, randReg(), $urandom);
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 149) == 0);
        end
        repeat (10) applyStimulus(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
